// File: rtl/channel_err_inj.sv
// ---------------------------------------------------------------------------
// channel_err_inj
//   Channel-error injector placed between the rate-1/2 convolutional encoder
//   and the Viterbi decoder. Each accepted 2-bit symbol is re-timed by one
//   register stage and may be corrupted. The corruption mode is one of
//   clean, periodic, pseudo-random or burst. The block also reports the clean
//   reference symbol and saturating symbol / bit-error counters.
//
// Parameters
//   PERIOD    : injection period in accepted symbols (periodic/burst), >= 2
//   BURST     : corrupted symbols per burst, 1..PERIOD-1
//   LFSR_SEED : reset/reseed value of the random-mode LFSR, nonzero
//   CNT_W     : width of the symbol and bit-error counters
//
// Ports
//   clk          : clock
//   rst          : asynchronous active-low reset
//   valid_i      : sym_i valid
//   sym_i        : encoder output symbol
//   mode_i       : 00 clean, 01 periodic, 10 random, 11 burst
//   mask_i       : bits inverted in periodic/burst modes
//   thresh_i     : random-mode threshold (corrupt when lfsr[7:0] < thresh_i)
//   clr_i        : synchronous clear of counters, index, FSM and LFSR
//   valid_o      : sym_o valid
//   sym_o        : possibly corrupted symbol
//   sym_clean_o  : uncorrupted copy of sym_o
//   err_o        : sym_o differs from sym_clean_o
//   sym_ct_o     : accepted-symbol count (saturating)
//   bit_err_ct_o : total inverted bits (saturating)
// ---------------------------------------------------------------------------
module channel_err_inj #(
    parameter int          PERIOD    = 8,
    parameter int          BURST     = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [1:0]       sym_i,
    input  logic [1:0]       mode_i,
    input  logic [1:0]       mask_i,
    input  logic [7:0]       thresh_i,
    input  logic             clr_i,
    output logic             valid_o,
    output logic [1:0]       sym_o,
    output logic [1:0]       sym_clean_o,
    output logic             err_o,
    output logic [CNT_W-1:0] sym_ct_o,
    output logic [CNT_W-1:0] bit_err_ct_o
);

    localparam int IW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int RW = $clog2(PERIOD + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [RW-1:0]   burst_rem;
    logic [15:0]     lfsr;

    logic            trigger;
    logic [1:0]      flip;
    logic [1:0]      rand_flip;
    logic [1:0]      flip_pop;
    logic [15:0]     lfsr_nx;
    logic [IW-1:0]   idx_nx;
    logic [CNT_W-1:0] sym_ct_nx;
    logic [CNT_W:0]   bit_sum;
    logic [CNT_W-1:0] bit_ct_nx;

    always_comb begin
        trigger   = (idx == '0);
        // A zero random pattern would be a silent "hit"; force bit0 instead.
        rand_flip = (lfsr[9:8] == 2'b00) ? 2'b01 : lfsr[9:8];
        flip      = '0;
        case (mode_i)
            2'b01: if (trigger) flip = mask_i;
            2'b10: if (lfsr[7:0] < thresh_i) flip = rand_flip;
            2'b11: if (state == ACTIVE || trigger) flip = mask_i;
            default: flip = '0;
        endcase

        // Galois right-shift form of x^16+x^14+x^13+x^11+1.
        lfsr_nx  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        idx_nx   = (idx == IW'(PERIOD - 1)) ? '0 : idx + 1'b1;
        flip_pop = {1'b0, flip[0]} + {1'b0, flip[1]};

        sym_ct_nx = (&sym_ct_o) ? sym_ct_o : sym_ct_o + 1'b1;
        bit_sum   = {1'b0, bit_err_ct_o} + {{(CNT_W-1){1'b0}}, flip_pop};
        bit_ct_nx = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o      <= 1'b0;
            sym_o        <= '0;
            sym_clean_o  <= '0;
            err_o        <= 1'b0;
            sym_ct_o     <= '0;
            bit_err_ct_o <= '0;
            idx          <= '0;
            state        <= IDLE;
            burst_rem    <= '0;
            lfsr         <= LFSR_SEED;
        end else if (clr_i) begin
            // A symbol arriving with clear is forwarded uncorrupted and uncounted.
            valid_o      <= valid_i;
            if (valid_i) begin
                sym_o       <= sym_i;
                sym_clean_o <= sym_i;
                err_o       <= 1'b0;
            end
            sym_ct_o     <= '0;
            bit_err_ct_o <= '0;
            idx          <= '0;
            state        <= IDLE;
            burst_rem    <= '0;
            lfsr         <= LFSR_SEED;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                sym_o        <= sym_i ^ flip;
                sym_clean_o  <= sym_i;
                err_o        <= |flip;
                sym_ct_o     <= sym_ct_nx;
                bit_err_ct_o <= bit_ct_nx;
                idx          <= idx_nx;
                lfsr         <= lfsr_nx;
            end

            // Burst FSM: leaving burst mode aborts any burst on the next edge,
            // even without a valid symbol.
            if (mode_i != 2'b11) begin
                state     <= IDLE;
                burst_rem <= '0;
            end else if (valid_i) begin
                if (state == ACTIVE) begin
                    if (burst_rem <= RW'(1)) begin
                        state     <= IDLE;
                        burst_rem <= '0;
                    end else begin
                        burst_rem <= burst_rem - 1'b1;
                    end
                end else if (trigger && BURST > 1) begin
                    state     <= ACTIVE;
                    burst_rem <= RW'(BURST - 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_channel_err_inj.sv
module tb_channel_err_inj;

    localparam int          P    = 8;
    localparam int          B    = 2;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          CMAX = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v = 1'b0, cl = 1'b0;
    logic [1:0]  s = '0, md = '0, mk = '0;
    logic [7:0]  th = '0;
    logic        valid_o, err_o;
    logic [1:0]  sym_o, sym_clean_o;
    logic [15:0] sym_ct_o, bit_err_ct_o;

    // small-counter instance
    logic        v2 = 1'b0, cl2 = 1'b0;
    logic [1:0]  s2 = '0, md2 = 2'b01, mk2 = 2'b11;
    logic [7:0]  th2 = '0;
    logic        valid_o2, err_o2;
    logic [1:0]  sym_o2, sym_clean_o2;
    logic [3:0]  sym_ct_o2, bit_err_ct_o2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    channel_err_inj #(.PERIOD(P), .BURST(B), .LFSR_SEED(SEED), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid_i(v), .sym_i(s), .mode_i(md), .mask_i(mk),
        .thresh_i(th), .clr_i(cl), .valid_o(valid_o), .sym_o(sym_o),
        .sym_clean_o(sym_clean_o), .err_o(err_o), .sym_ct_o(sym_ct_o),
        .bit_err_ct_o(bit_err_ct_o)
    );

    channel_err_inj #(.PERIOD(2), .BURST(1), .LFSR_SEED(SEED), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .valid_i(v2), .sym_i(s2), .mode_i(md2), .mask_i(mk2),
        .thresh_i(th2), .clr_i(cl2), .valid_o(valid_o2), .sym_o(sym_o2),
        .sym_clean_o(sym_clean_o2), .err_o(err_o2), .sym_ct_o(sym_ct_o2),
        .bit_err_ct_o(bit_err_ct_o2)
    );

    // ---------------- reference model (symbol-count based) ----------------
    int unsigned m_idx, m_left;
    logic [15:0] m_lfsr;
    int          m_ct, m_bct;
    logic        e_valid, e_err;
    logic [1:0]  e_sym, e_clean;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_left = 0; m_lfsr = SEED; m_ct = 0; m_bct = 0;
        e_valid = 0; e_err = 0; e_sym = '0; e_clean = '0;
    endtask

    task automatic model_edge();
        logic [1:0] f;
        f = 2'b00;
        if (cl) begin
            m_idx = 0; m_left = 0; m_lfsr = SEED; m_ct = 0; m_bct = 0;
            e_valid = v;
            if (v) begin e_sym = s; e_clean = s; e_err = 0; end
        end else if (v) begin
            case (md)
                2'b01: if (m_idx == 0) f = mk;
                2'b10: if (m_lfsr[7:0] < th) begin
                           f = m_lfsr[9:8];
                           if (f == 2'b00) f = 2'b01;
                       end
                2'b11: if (m_left > 0) begin
                           f = mk; m_left = m_left - 1;
                       end else if (m_idx == 0) begin
                           f = mk; m_left = B - 1;
                       end
                default: f = 2'b00;
            endcase
            e_valid = 1; e_clean = s; e_sym = s ^ f; e_err = |f;
            m_ct  = sat(m_ct + 1);
            m_bct = sat(m_bct + int'(f[0]) + int'(f[1]));
            m_idx = (m_idx + 1) % P;
            m_lfsr = lfsr_step(m_lfsr);
        end else begin
            e_valid = 0;
        end
        if (md != 2'b11) m_left = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("valid_o", 32'(valid_o), 32'(e_valid));
        check("sym_o", 32'(sym_o), 32'(e_sym));
        check("sym_clean_o", 32'(sym_clean_o), 32'(e_clean));
        check("err_o", 32'(err_o), 32'(e_err));
        check("sym_ct_o", 32'(sym_ct_o), 32'(m_ct));
        check("bit_err_ct_o", 32'(bit_err_ct_o), 32'(m_bct));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic v; logic [1:0] s; logic [1:0] md; logic [1:0] mk; logic [7:0] th; logic cl;
        logic ev; logic [1:0] es; logic ee; int ect; int ebct;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mkv(input logic vv, input logic [1:0] ss, input logic [1:0] mm,
                                 input logic [1:0] kk, input logic [7:0] tt, input logic cc,
                                 input logic ev, input logic [1:0] es, input logic ee,
                                 input int ect, input int ebct);
        vec_t r;
        r.v = vv; r.s = ss; r.md = mm; r.mk = kk; r.th = tt; r.cl = cc;
        r.ev = ev; r.es = es; r.ee = ee; r.ect = ect; r.ebct = ebct;
        return r;
    endfunction

    int errs, bad_bits, sent, cyc;

    initial begin
        // --- reset state ---
        model_reset();
        #12;
        check("reset valid_o", 32'(valid_o), 0);
        check("reset sym_o", 32'(sym_o), 0);
        check("reset err_o", 32'(err_o), 0);
        check("reset sym_ct_o", 32'(sym_ct_o), 0);
        check("reset bit_err_ct_o", 32'(bit_err_ct_o), 0);
        check("reset sym_ct_o2", 32'(sym_ct_o2), 0);
        @(negedge clk); rst = 1'b1;

        // --- table-driven directed vectors ---
        tbl[0]  = mkv(0, 2'b00, 2'b01, 2'b10, 8'd0, 1, 0, 2'b00, 0, 0, 0);
        tbl[1]  = mkv(1, 2'b01, 2'b01, 2'b10, 8'd0, 0, 1, 2'b11, 1, 1, 1);
        tbl[2]  = mkv(1, 2'b10, 2'b01, 2'b10, 8'd0, 0, 1, 2'b10, 0, 2, 1);
        tbl[3]  = mkv(0, 2'b11, 2'b01, 2'b10, 8'd0, 0, 0, 2'b00, 0, 2, 1);
        tbl[4]  = mkv(1, 2'b11, 2'b00, 2'b11, 8'd0, 0, 1, 2'b11, 0, 3, 1);
        tbl[5]  = mkv(1, 2'b00, 2'b11, 2'b11, 8'd0, 0, 1, 2'b00, 0, 4, 1);
        tbl[6]  = mkv(1, 2'b01, 2'b11, 2'b11, 8'd0, 0, 1, 2'b01, 0, 5, 1);
        tbl[7]  = mkv(1, 2'b10, 2'b11, 2'b11, 8'd0, 0, 1, 2'b10, 0, 6, 1);
        tbl[8]  = mkv(1, 2'b11, 2'b11, 2'b11, 8'd0, 0, 1, 2'b11, 0, 7, 1);
        tbl[9]  = mkv(1, 2'b00, 2'b11, 2'b11, 8'd0, 0, 1, 2'b00, 0, 8, 1);
        tbl[10] = mkv(1, 2'b01, 2'b11, 2'b11, 8'd0, 0, 1, 2'b10, 1, 9, 3);
        tbl[11] = mkv(1, 2'b10, 2'b11, 2'b01, 8'd0, 0, 1, 2'b11, 1, 10, 4);
        tbl[12] = mkv(1, 2'b10, 2'b11, 2'b11, 8'd0, 0, 1, 2'b10, 0, 11, 4);
        tbl[13] = mkv(1, 2'b11, 2'b01, 2'b11, 8'd0, 1, 1, 2'b11, 0, 0, 0);
        tbl[14] = mkv(1, 2'b00, 2'b01, 2'b01, 8'd0, 0, 1, 2'b01, 1, 1, 1);
        tbl[15] = mkv(1, 2'b10, 2'b10, 2'b11, 8'd0, 0, 1, 2'b10, 0, 2, 1);
        for (int i = 0; i < 16; i++) begin
            v = tbl[i].v; s = tbl[i].s; md = tbl[i].md; mk = tbl[i].mk;
            th = tbl[i].th; cl = tbl[i].cl;
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("vec%0d sym_o", i), 32'(sym_o), 32'(tbl[i].es));
                check($sformatf("vec%0d err_o", i), 32'(err_o), 32'(tbl[i].ee));
            end
            check($sformatf("vec%0d sym_ct_o", i), 32'(sym_ct_o), 32'(tbl[i].ect));
            check($sformatf("vec%0d bit_err_ct_o", i), 32'(bit_err_ct_o), 32'(tbl[i].ebct));
        end
        cl = 0;

        // --- 1: clean mode, 256 symbols ---
        cl = 1; v = 0; tick(); cl = 0;
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            v = 1; md = 2'b00; mk = 2'($urandom); s = 2'($urandom);
            tick();
            if (err_o) errs++;
        end
        v = 0;
        check("clean errors", 32'(errs), 0);
        check("clean sym_ct", 32'(sym_ct_o), 256);
        check("clean bit_err_ct", 32'(bit_err_ct_o), 0);

        // --- 2: periodic, mask 10 ---
        cl = 1; tick(); cl = 0;
        errs = 0; bad_bits = 0;
        for (int i = 0; i < 256; i++) begin
            v = 1; md = 2'b01; mk = 2'b10; s = 2'($urandom);
            tick();
            if (err_o) errs++;
            if ((sym_o ^ sym_clean_o) == 2'b01 || (sym_o ^ sym_clean_o) == 2'b11) bad_bits++;
            if (err_o && (i % P) != 0) bad_bits++;
        end
        v = 0;
        check("periodic errors", 32'(errs), 32);
        check("periodic bit0 or position hits", 32'(bad_bits), 0);
        check("periodic bit_err_ct", 32'(bit_err_ct_o), 32);

        // --- 3: burst with gaps every 3rd cycle ---
        cl = 1; tick(); cl = 0;
        errs = 0; sent = 0; cyc = 0;
        while (sent < 64 && cyc < 200) begin
            md = 2'b11; mk = 2'b11; s = 2'($urandom);
            v = (cyc % 3 != 2);
            tick();
            if (v) begin
                if (err_o) errs++;
                check("burst position", 32'(err_o), 32'((sent % P) < B));
                sent++;
            end
            cyc++;
        end
        v = 0;
        check("burst symbols sent", 32'(sent), 64);
        check("burst errors", 32'(errs), 16);
        check("burst bit_err_ct", 32'(bit_err_ct_o), 32);

        // --- 4: random mode ---
        cl = 1; tick(); cl = 0;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            v = 1; md = 2'b10; th = 8'd0; s = 2'($urandom);
            tick();
            if (err_o) errs++;
        end
        check("random thresh0 errors", 32'(errs), 0);
        cl = 1; v = 0; tick(); cl = 0;
        for (int i = 0; i < 1000; i++) begin
            v = 1; md = 2'b10; th = 8'hFF; s = 2'($urandom);
            tick();
        end
        v = 0;
        check("random sym_ct", 32'(sym_ct_o), 1000);

        // --- 5: clr with valid after 10 periodic symbols ---
        cl = 1; tick(); cl = 0;
        for (int i = 0; i < 10; i++) begin
            v = 1; md = 2'b01; mk = 2'b01; s = 2'($urandom);
            tick();
        end
        cl = 1; v = 1; s = 2'b10; tick(); cl = 0;
        check("clr symbol clean", 32'(sym_o), 32'h2);
        check("clr sym_ct zero", 32'(sym_ct_o), 0);
        s = 2'b10; tick();
        check("after clr err_o", 32'(err_o), 1);
        check("after clr sym_o", 32'(sym_o), 32'h3);
        v = 0;

        // --- 6: saturating 4-bit counters, PERIOD=2, mask 11 ---
        for (int i = 0; i < 40; i++) begin
            v2 = 1; s2 = 2'($urandom);
            @(posedge clk); #1;
            check("sat err_o2", 32'(err_o2), 32'((i % 2) == 0));
            check("sat sym_o2", 32'(sym_o2), 32'((i % 2 == 0) ? (s2 ^ 2'b11) : s2));
            check("sat sym_ct_o2", 32'(sym_ct_o2), 32'((i + 1 > 15) ? 15 : i + 1));
            check("sat bit_err_ct_o2", 32'(bit_err_ct_o2),
                  32'((2 * ((i + 2) / 2) > 15) ? 15 : 2 * ((i + 2) / 2)));
        end
        v2 = 0;

        // --- randomized mix against the model ---
        for (int i = 0; i < 2000; i++) begin
            v  = ($urandom_range(3, 0) != 0);
            cl = ($urandom_range(63, 0) == 0);
            md = 2'($urandom); mk = 2'($urandom); th = 8'($urandom); s = 2'($urandom);
            tick();
        end
        cl = 0; v = 0;

        // --- reset mid-burst ---
        cl = 1; tick(); cl = 0;
        v = 1; md = 2'b11; mk = 2'b11; s = 2'b00; tick();
        check("burst started", 32'(err_o), 1);
        #2 rst = 1'b0;
        #1;
        check("async rst valid_o", 32'(valid_o), 0);
        check("async rst sym_o", 32'(sym_o), 0);
        check("async rst sym_clean_o", 32'(sym_clean_o), 0);
        check("async rst err_o", 32'(err_o), 0);
        check("async rst sym_ct_o", 32'(sym_ct_o), 0);
        check("async rst bit_err_ct_o", 32'(bit_err_ct_o), 0);
        model_reset();
        v = 0;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            v = 1; md = 2'b11; mk = 2'b01; s = 2'($urandom);
            tick();
        end
        v = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
